// File: rtl/rf_exec_pkg.sv
// Shared constants and enums for the register-file execute/writeback unit.
//   DATA_W / ADDR_W : register width and register address width
//   op_e            : instruction opcodes
//   state_e         : sequencer FSM states
package rf_exec_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_MUL = 3'd6,
    OP_MOV = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_MUL  = 3'd3,
    S_WB   = 3'd4
  } state_e;
endpackage

// File: rtl/rf_shift_add_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
//   i_start : pulse; operands i_a/i_b are sampled and bit 0 is processed
//             on the same edge
//   o_busy  : high while bits 1..DATA_W-1 are being processed
//   o_prod  : 2*DATA_W product, valid once o_busy falls after a start
// Folding bit 0 into the start edge makes o_busy span DATA_W-1 cycles,
// so the caller sees o_busy low exactly DATA_W cycles after start.
module rf_shift_add_mul
  import rf_exec_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  output logic                o_busy,
  output logic [2*DATA_W-1:0] o_prod
);
  logic [2*DATA_W-1:0] r_acc;
  logic [2*DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [3:0]          r_cnt;
  logic                r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= i_a[0] ? {{DATA_W{1'b0}}, i_b} : '0;
      r_mcand  <= {{(DATA_W-1){1'b0}}, i_b, 1'b0};
      r_mplier <= i_a >> 1;
      r_cnt    <= 4'd1;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 4'd1;
      if (r_cnt == 4'd15) r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_prod = r_acc;
endmodule

// File: rtl/rf_exec_unit.sv
// Execute/writeback sequencer around a 16x16 2R1W register file.
//   instr_*       : valid/ready instruction input (op, rd, rs1, rs2)
//   rf_rd_addr1/2 : read addresses (latched rs1/rs2); rf_rd_data1/2 return
//   rf_wr_*       : single write-back per instruction, in the WB cycle
//   done          : one-cycle pulse alongside rf_wr_en
//   flag_zero/carry : status of the last completed instruction
// Sequence: IDLE -> READ -> EXEC -> [MUL x16] -> WB -> IDLE.
module rf_exec_unit
  import rf_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  output logic [ADDR_W-1:0] rf_rd_addr1,
  output logic [ADDR_W-1:0] rf_rd_addr2,
  input  logic [DATA_W-1:0] rf_rd_data1,
  input  logic [DATA_W-1:0] rf_rd_data2,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              done,
  output logic              flag_zero,
  output logic              flag_carry
);
  state_e              r_state, w_next;
  op_e                 r_op;
  logic [ADDR_W-1:0]   r_rd, r_rs1, r_rs2;
  logic [DATA_W-1:0]   r_opa, r_opb, r_result;
  logic                r_carry, r_fz, r_fc;

  logic                w_mul_start, w_mul_busy;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W:0]     w_sum, w_diff;
  logic [DATA_W-1:0]   w_alu_res;
  logic                w_alu_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_mul_start = 1'b0;
    case (r_state)
      S_IDLE: if (instr_valid) w_next = S_READ;
      S_READ: w_next = S_EXEC;
      S_EXEC: begin
        if (r_op == OP_MUL) begin
          w_next      = S_MUL;
          w_mul_start = 1'b1;
        end else begin
          w_next = S_WB;
        end
      end
      S_MUL:  if (!w_mul_busy) w_next = S_WB;
      S_WB:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Single-cycle ALU; bit DATA_W of the widened difference is the borrow.
  assign w_sum  = {1'b0, r_opa} + {1'b0, r_opb};
  assign w_diff = {1'b0, r_opa} - {1'b0, r_opb};

  always_comb begin
    w_alu_res   = r_opa;
    w_alu_carry = 1'b0;
    case (r_op)
      OP_ADD: begin w_alu_res = w_sum[DATA_W-1:0];  w_alu_carry = w_sum[DATA_W];  end
      OP_SUB: begin w_alu_res = w_diff[DATA_W-1:0]; w_alu_carry = w_diff[DATA_W]; end
      OP_AND: w_alu_res = r_opa & r_opb;
      OP_OR:  w_alu_res = r_opa | r_opb;
      OP_XOR: w_alu_res = r_opa ^ r_opb;
      OP_SLL: w_alu_res = r_opa << r_opb[3:0];
      default: w_alu_res = r_opa;
    endcase
  end

  rf_shift_add_mul u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_mul_start),
    .i_a     (r_opa),
    .i_b     (r_opb),
    .o_busy  (w_mul_busy),
    .o_prod  (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_ADD;
      r_rd     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_fz     <= 1'b0;
      r_fc     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (instr_valid) begin
          r_op  <= op_e'(instr_op);
          r_rd  <= instr_rd;
          r_rs1 <= instr_rs1;
          r_rs2 <= instr_rs2;
        end
        S_READ: begin
          r_opa <= rf_rd_data1;
          r_opb <= rf_rd_data2;
        end
        S_EXEC: if (r_op != OP_MUL) begin
          r_result <= w_alu_res;
          r_carry  <= w_alu_carry;
        end
        S_MUL: if (!w_mul_busy) begin
          r_result <= w_prod[DATA_W-1:0];
          r_carry  <= |w_prod[2*DATA_W-1:DATA_W];
        end
        S_WB: begin
          r_fz <= (r_result == '0);
          r_fc <= r_carry;
        end
        default: ;
      endcase
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign rf_rd_addr1 = r_rs1;
  assign rf_rd_addr2 = r_rs2;
  assign rf_wr_en    = (r_state == S_WB);
  assign done        = (r_state == S_WB);
  assign rf_wr_addr  = r_rd;
  assign rf_wr_data  = r_result;
  assign flag_zero   = r_fz;
  assign flag_carry  = r_fc;
endmodule

// File: tb/tb_rf_exec_unit.sv
module tb_rf_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  instr_op = '0;
  logic [3:0]  instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic [3:0]  rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
  logic [15:0] rf_rd_data1, rf_rd_data2, rf_wr_data;
  logic        rf_wr_en, done, flag_zero, flag_carry;

  logic [15:0] regs [16];
  logic        preload = 1'b1;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  rf_exec_unit dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .done(done), .flag_zero(flag_zero), .flag_carry(flag_carry)
  );

  // Register-file model: combinational reads, write on the rising edge.
  assign rf_rd_data1 = regs[rf_rd_addr1];
  assign rf_rd_data2 = regs[rf_rd_addr2];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
      regs[1]  <= 16'hB274;
      regs[2]  <= 16'hEA7C;
      regs[7]  <= 16'h0003;
      regs[8]  <= 16'h0005;
      regs[11] <= 16'h1234;
      regs[13] <= 16'h5555;
    end else if (rf_wr_en) begin
      regs[rf_wr_addr] <= rf_wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] rd, rs1, rs2);
    instr_op  = op;
    instr_rd  = rd;
    instr_rs1 = rs1;
    instr_rs2 = rs2;
  endtask

  // Wait (bounded) for ready at a falling edge; returns 1 if seen.
  task automatic wait_ready(output bit ok);
    int k = 0;
    while (!instr_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    ok = instr_ready;
  endtask

  // Issue one instruction and observe 22 cycles after the accept edge
  // (cycle 0). Reports first write cycle, number of write cycles,
  // first ready cycle and cycles where done and wr_en disagree.
  task automatic exec(input logic [2:0] op, input logic [3:0] rd, rs1, rs2,
                      output int wr_cyc, output int n_wr, output int rdy_cyc,
                      output int n_dmis);
    bit ok;
    @(negedge clk);
    drive(op, rd, rs1, rs2);
    instr_valid = 1'b1;
    wait_ready(ok);
    if (!ok) chk("exec_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    wr_cyc = -1; n_wr = 0; rdy_cyc = -1; n_dmis = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("rd_addr1", {28'd0, rf_rd_addr1}, {28'd0, rs1});
        chk("rd_addr2", {28'd0, rf_rd_addr2}, {28'd0, rs2});
      end
      if (rf_wr_en) begin
        n_wr++;
        if (wr_cyc < 0) wr_cyc = c;
      end
      if (done !== rf_wr_en) n_dmis++;
      if (instr_ready && rdy_cyc < 0) rdy_cyc = c;
    end
  endtask

  int  wc, nw, rc, dm;
  int  acc2, wr1, wr2, nwr;
  bit  ok;

  initial begin
    // Reset state, checked while reset is still asserted.
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_wr_en", {31'd0, rf_wr_en},    32'd0);
    chk("rst_done",  {31'd0, done},        32'd0);
    chk("rst_addr",  {24'd0, rf_rd_addr1, rf_rd_addr2}, 32'd0);
    chk("rst_wdata", {12'd0, rf_wr_addr, rf_wr_data}, 32'd0);
    chk("rst_flags", {30'd0, flag_zero, flag_carry}, 32'd0);
    preload = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);

    // ADD r3,r1,r2: B274+EA7C = 1_9CF0
    exec(3'd0, 4'd3, 4'd1, 4'd2, wc, nw, rc, dm);
    chk("add_wr_cyc", wc, 3);
    chk("add_wr_cnt", nw, 1);
    chk("add_rdy_cyc", rc, 4);
    chk("add_done", dm, 0);
    chk("add_r3", {16'd0, regs[3]}, 32'h9CF0);
    chk("add_flags", {30'd0, flag_zero, flag_carry}, 32'b01);

    exec(3'd1, 4'd4, 4'd1, 4'd1, wc, nw, rc, dm);
    chk("sub_r4", {16'd0, regs[4]}, 32'h0000);
    chk("sub_r4_flags", {30'd0, flag_zero, flag_carry}, 32'b10);

    exec(3'd1, 4'd5, 4'd2, 4'd1, wc, nw, rc, dm);
    chk("sub_r5", {16'd0, regs[5]}, 32'h3808);
    chk("sub_r5_flags", {30'd0, flag_zero, flag_carry}, 32'b00);

    exec(3'd1, 4'd6, 4'd1, 4'd2, wc, nw, rc, dm);
    chk("sub_r6", {16'd0, regs[6]}, 32'hC7F8);
    chk("sub_r6_flags", {30'd0, flag_zero, flag_carry}, 32'b01);

    // A few more ALU ops on r1/r2 (B274, EA7C).
    exec(3'd2, 4'd12, 4'd1, 4'd2, wc, nw, rc, dm);
    chk("and_r12", {16'd0, regs[12]}, 32'hA274);
    exec(3'd3, 4'd12, 4'd1, 4'd2, wc, nw, rc, dm);
    chk("or_r12", {16'd0, regs[12]}, 32'hFA7C);
    exec(3'd5, 4'd12, 4'd7, 4'd8, wc, nw, rc, dm);
    chk("sll_r12", {16'd0, regs[12]}, 32'h0060);
    exec(3'd7, 4'd12, 4'd2, 4'd1, wc, nw, rc, dm);
    chk("mov_r12", {16'd0, regs[12]}, 32'hEA7C);

    // MUL r9,r7,r8: 3*5
    exec(3'd6, 4'd9, 4'd7, 4'd8, wc, nw, rc, dm);
    chk("mul_wr_cyc", wc, 19);
    chk("mul_wr_cnt", nw, 1);
    chk("mul_rdy_cyc", rc, 20);
    chk("mul_done", dm, 0);
    chk("mul_r9", {16'd0, regs[9]}, 32'h000F);
    chk("mul_flags", {30'd0, flag_zero, flag_carry}, 32'b00);

    // MUL r9,r1,r2: high half nonzero.
    exec(3'd6, 4'd9, 4'd1, 4'd2, wc, nw, rc, dm);
    chk("mul2_wr_cyc", wc, 19);
    chk("mul2_carry", {31'd0, flag_carry}, 32'd1);

    // Dependent pair with valid held: ADD r3,r1,r2 ; XOR r10,r3,r3
    @(negedge clk);
    regs_clear_r3();
    drive(3'd0, 4'd3, 4'd1, 4'd2);
    instr_valid = 1'b1;
    wait_ready(ok);
    if (!ok) chk("dep_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 drive(3'd4, 4'd10, 4'd3, 4'd3);
    acc2 = -1; wr1 = -1; wr2 = -1; nwr = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (rf_wr_en) begin
        nwr++;
        if (wr1 < 0) wr1 = c; else if (wr2 < 0) wr2 = c;
      end
      if (instr_ready && instr_valid && acc2 < 0) begin
        acc2 = c;
        @(posedge clk);
        #1 instr_valid = 1'b0;
      end
    end
    if (instr_valid) instr_valid = 1'b0;
    chk("dep_acc2", acc2, 4);
    chk("dep_wr1", wr1, 3);
    chk("dep_wr2", wr2, 7);
    chk("dep_nwr", nwr, 2);
    chk("dep_r3", {16'd0, regs[3]}, 32'h9CF0);
    chk("dep_r10", {16'd0, regs[10]}, 32'h0000);
    chk("dep_zero", {31'd0, flag_zero}, 32'd1);

    // Fields change while busy: only ADD r12,r7,r8 (=8) executes.
    @(negedge clk);
    drive(3'd0, 4'd12, 4'd7, 4'd8);
    instr_valid = 1'b1;
    wait_ready(ok);
    if (!ok) chk("chg_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 drive(3'd1, 4'd13, 4'd1, 4'd2);
    nwr = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rf_wr_en) nwr++;
      if (c == 3) instr_valid = 1'b0;
    end
    chk("chg_nwr", nwr, 1);
    chk("chg_r12", {16'd0, regs[12]}, 32'h0008);
    chk("chg_r13", {16'd0, regs[13]}, 32'h5555);

    // Reset at cycle 10 of MUL r11,r7,r8: nothing written.
    @(negedge clk);
    drive(3'd6, 4'd11, 4'd7, 4'd8);
    instr_valid = 1'b1;
    wait_ready(ok);
    if (!ok) chk("rstm_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstm_ready", {31'd0, instr_ready}, 32'd1);
    chk("rstm_wr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("rstm_wdata", {16'd0, rf_wr_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nwr = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (rf_wr_en) nwr++;
    end
    chk("rstm_nwr", nwr, 0);
    chk("rstm_r11", {16'd0, regs[11]}, 32'h1234);
    chk("rstm_ready_after", {31'd0, instr_ready}, 32'd1);

    exec(3'd0, 4'd14, 4'd1, 4'd2, wc, nw, rc, dm);
    chk("post_wr_cyc", wc, 3);
    chk("post_r14", {16'd0, regs[14]}, 32'h9CF0);
    chk("post_flags", {30'd0, flag_zero, flag_carry}, 32'b01);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // r3 already holds 9CF0 from the first ADD; nothing to clear, but the
  // dependent test must not rely on that, so r3 is rewritten by the ADD.
  task automatic regs_clear_r3();
  endtask
endmodule
